// File: rtl/wb_bridge_arbiter.sv
// wb_bridge_arbiter: round-robin arbiter sharing the bridge's single WISHBONE
// slave port between NUM_MASTERS masters. A grant is held for the whole cyc
// tenure; the pointer moves past the owner on release.
// Optional stall abort is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bridge_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [4*NUM_MASTERS-1:0]        m_sel_i,
    input  logic [AWIDTH*NUM_MASTERS-1:0]   m_addr_i,
    input  logic [DWIDTH*NUM_MASTERS-1:0]   m_data_i,
    output logic [DWIDTH-1:0]               m_data_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [3:0]                      s_sel_o,
    output logic [AWIDTH-1:0]               s_addr_o,
    output logic [DWIDTH-1:0]               s_data_o,
    input  logic [DWIDTH-1:0]               s_data_i,
    input  logic                            s_ack_i,
    output logic [NUM_MASTERS-1:0]          gnt_o,
    output logic                            busy_o,
    output logic                            timeout_o
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    // Reject unsupported configurations at elaboration.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("wb_bridge_arbiter: unsupported NUM_MASTERS or TIMEOUT_CYC");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   pick;
    logic               found;
    int unsigned        scan_idx;
    logic               abort;

    logic [3:0]         sel_arr  [NUM_MASTERS];
    logic [AWIDTH-1:0]  addr_arr [NUM_MASTERS];
    logic [DWIDTH-1:0]  data_arr [NUM_MASTERS];

    // Unpack the per-master buses into indexable arrays.
    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign sel_arr[k]  = m_sel_i[4*k +: 4];
        assign addr_arr[k] = m_addr_i[AWIDTH*k +: AWIDTH];
        assign data_arr[k] = m_data_i[DWIDTH*k +: DWIDTH];
    end

    // Round-robin search: first requester at or above the pointer, with wrap.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            scan_idx = 32'(ptr) + i;
            if (scan_idx >= NUM_MASTERS) begin
                scan_idx = scan_idx - NUM_MASTERS;
            end
            if (!found && m_cyc_i[IDX_W'(scan_idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(scan_idx);
            end
        end
    end

    // Pointer moves one past the releasing owner, modulo NUM_MASTERS.
    assign next_ptr = (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + IDX_W'(1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]   stall_cnt;
    logic               stall;

    // A stalled beat: owner strobing while the bridge withholds ack.
    assign stall     = (state == GRANT) && m_stb_i[owner] && !s_ack_i;
    assign abort     = stall && (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout_o = abort;

    // Stall counter, cleared by ack, idle strobe, release or abort.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!stall || abort || !m_cyc_i[owner]) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    assign abort     = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Grant FSM: registered grant, busy, owner index and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            gnt_o  <= '0;
            busy_o <= 1'b0;
            owner  <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner  <= pick;
                        gnt_o  <= NUM_MASTERS'(1) << pick;
                        busy_o <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!m_cyc_i[owner] || abort) begin
                        gnt_o  <= '0;
                        busy_o <= 1'b0;
                        ptr    <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Owner's request muxed onto the bridge; ack routed back to the owner only.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        m_ack_o  = '0;
        m_data_o = s_data_i;
        if (state == GRANT) begin
            s_cyc_o        = m_cyc_i[owner];
            s_stb_o        = m_stb_i[owner];
            s_we_o         = m_we_i[owner];
            s_sel_o        = sel_arr[owner];
            s_addr_o       = addr_arr[owner];
            s_data_o       = data_arr[owner];
            m_ack_o[owner] = s_ack_i;
        end
        if (abort) begin
            s_cyc_o        = 1'b0;
            s_stb_o        = 1'b0;
            m_ack_o[owner] = 1'b1;
            m_data_o       = '0;
        end
    end

endmodule

// File: tb/tb_wb_bridge_arbiter.sv
// Bench for wb_bridge_arbiter: directed scenarios plus randomized tenures
// checked against a round-robin model of the arbitration rules.
module tb_wb_bridge_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NM-1:0]     m_cyc = '0;
    logic [NM-1:0]     m_stb = '0;
    logic [NM-1:0]     m_we = '0;
    logic [4*NM-1:0]   m_sel = '0;
    logic [AW*NM-1:0]  m_addr = '0;
    logic [DW*NM-1:0]  m_data = '0;
    logic [DW-1:0]     m_data_o;
    logic [NM-1:0]     m_ack;
    logic              s_cyc, s_stb, s_we;
    logic [3:0]        s_sel;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_data_o;
    logic [DW-1:0]     s_data_i = '0;
    logic              s_ack = 1'b0;
    logic [NM-1:0]     gnt;
    logic              busy;
    logic              timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int mdl_ptr  = 0;

    wb_bridge_arbiter #(
        .NUM_MASTERS (NM),
        .DWIDTH      (DW),
        .AWIDTH      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_sel_i   (m_sel),
        .m_addr_i  (m_addr),
        .m_data_i  (m_data),
        .m_data_o  (m_data_o),
        .m_ack_o   (m_ack),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_sel_o   (s_sel),
        .s_addr_o  (s_addr),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack),
        .gnt_o     (gnt),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NM-1:0] onehot(input int k);
        return NM'(1) << k;
    endfunction

    // Spec rule: first requester found scanning upward from the pointer, with wrap.
    function automatic int pick_model(input logic [NM-1:0] req);
        for (int i = 0; i < int'(NM); i++) begin
            if (req[(mdl_ptr + i) % NM]) return (mdl_ptr + i) % NM;
        end
        return -1;
    endfunction

    task automatic set_payload(input int k);
        m_we[k]          = 1'($urandom_range(0, 1));
        m_sel[k*4 +: 4]  = 4'($urandom);
        m_addr[k*AW +: AW] = AW'($urandom);
        m_data[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic check_mux(input string tag, input int w);
        chk({tag, "_ctl"}, {s_cyc, s_stb, s_we, s_sel}, {m_cyc[w], m_stb[w], m_we[w], m_sel[w*4 +: 4]});
        chk({tag, "_addr"}, s_addr, m_addr[w*AW +: AW]);
        chk({tag, "_wdata"}, s_data_o, m_data[w*DW +: DW]);
    endtask

    // One tenure, entered at posedge+1 of an IDLE cycle with requests driven.
    task automatic tenure(input int beats, input bit raise_others, input bit ack_on_drop,
                          input bit cont, output int w);
        logic [DW-1:0] rd;
        w = pick_model(m_cyc);
        chk("has_request", 64'(w >= 0), 64'd1);
        if (w < 0) return;
        s_ack    = 1'($urandom_range(0, 1));
        s_data_i = DW'($urandom);
        @(negedge clk);
        chk("idle_gnt", gnt, '0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_scyc", s_cyc, 1'b0);
        chk("idle_ack_ignored", m_ack, '0);
        @(posedge clk) #1;
        s_ack = 1'b0;
        if (raise_others) begin
            m_cyc = '1;
            m_stb = '1;
        end
        @(negedge clk);
        chk("grant", gnt, onehot(w));
        chk("grant_busy", busy, 1'b1);
        chk("grant_ack", m_ack, '0);
        check_mux("grant_mux", w);
        for (int b = 0; b < beats; b++) begin
            int d;
            d = $urandom_range(0, 2);
            for (int c = 0; c < d; c++) begin
                @(posedge clk) #1;
                @(negedge clk);
                chk("hold_gnt", gnt, onehot(w));
                chk("wait_ack", m_ack, '0);
            end
            @(posedge clk) #1;
            rd       = DW'($urandom);
            s_data_i = rd;
            s_ack    = 1'b1;
            if (ack_on_drop && b == beats - 1) begin
                m_cyc[w] = 1'b0;
                m_stb[w] = 1'b0;
            end
            @(negedge clk);
            chk("ack_route", m_ack, onehot(w));
            chk("rdata", m_data_o, rd);
            chk("beat_gnt", gnt, onehot(w));
            if (b < beats - 1) begin
                @(posedge clk) #1;
                s_ack = 1'b0;
                set_payload(w);
                @(negedge clk);
                check_mux("beat_mux", w);
            end
        end
        @(posedge clk) #1;
        s_ack = 1'b0;
        if (!ack_on_drop) begin
            m_cyc[w] = 1'b0;
            m_stb[w] = 1'b0;
            @(negedge clk);
            chk("rel_busy", busy, 1'b1);
            chk("rel_scyc", s_cyc, 1'b0);
            chk("rel_ack", m_ack, '0);
            @(posedge clk) #1;
        end
        mdl_ptr = (w + 1) % NM;
        if (cont) begin
            m_cyc[w] = 1'b1;
            m_stb[w] = 1'b1;
            set_payload(w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int seq [6];

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_gnt", gnt, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_scyc", s_cyc, 1'b0);
        chk("rst_ack", m_ack, '0);
        chk("rst_timeout", timeout, 1'b0);
        @(posedge clk) #1;
        rst = 1'b0;
        mdl_ptr = 0;

        // Master 0 single write, bridge acks two cycles into the grant
        @(posedge clk) #1;
        m_cyc = 2'b01;
        m_stb = 2'b01;
        m_we  = 2'b01;
        m_sel[3:0]   = 4'hF;
        m_addr[31:0] = 32'h0000_0100;
        m_data[31:0] = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("t1_scyc_same_cycle", s_cyc, 1'b0);
        @(posedge clk) #1;
        @(negedge clk);
        chk("t1_scyc", s_cyc, 1'b1);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_addr", s_addr, 32'h0000_0100);
        chk("t1_wdata", s_data_o, 32'hA5A5_A5A5);
        chk("t1_we", s_we, 1'b1);
        repeat (2) begin
            @(posedge clk) #1;
            @(negedge clk);
            chk("t1_no_ack", m_ack, 2'b00);
        end
        @(posedge clk) #1;
        s_ack    = 1'b1;
        s_data_i = 32'h1234_5678;
        @(negedge clk);
        chk("t1_ack", m_ack, 2'b01);
        chk("t1_rdata", m_data_o, 32'h1234_5678);
        @(posedge clk) #1;
        s_ack = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        @(negedge clk);
        chk("t1_rel_scyc", s_cyc, 1'b0);
        @(posedge clk) #1;
        mdl_ptr = 1;

        // Simultaneous request right after reset: master 0 first, then master 1
        rst = 1'b1;
        #2 rst = 1'b0;
        mdl_ptr = 0;
        set_payload(0);
        set_payload(1);
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tenure(1, 1'b0, 1'b0, 1'b0, w);
        chk("t2_first", 64'(w), 64'd0);
        tenure(1, 1'b0, 1'b0, 1'b0, w);
        chk("t2_second", 64'(w), 64'd1);

        // Continuous requests from both: strict alternation
        set_payload(0);
        set_payload(1);
        m_cyc = 2'b11;
        m_stb = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tenure($urandom_range(1, 2), 1'b0, 1'b0, 1'(i < 5), w);
            seq[i] = w;
        end
        for (int i = 0; i < 6; i++) chk("t3_order", 64'(seq[i]), 64'(i % 2));
        m_cyc = '0;
        m_stb = '0;
        @(posedge clk) #1;

        // Master 1 holds 4 beats while master 0 waits
        set_payload(1);
        m_cyc = 2'b10;
        m_stb = 2'b10;
        tenure(4, 1'b1, 1'b0, 1'b0, w);
        chk("t4_holder", 64'(w), 64'd1);
        tenure(1, 1'b0, 1'b0, 1'b0, w);
        chk("t4_next", 64'(w), 64'd0);

        // Ack coinciding with cyc drop still reaches the owner
        set_payload(0);
        m_cyc = 2'b01;
        m_stb = 2'b01;
        tenure(2, 1'b0, 1'b1, 1'b0, w);
        chk("ack_on_drop_owner", 64'(w), 64'd0);

        // Randomized tenures
        for (int it = 0; it < 12; it++) begin
            set_payload(0);
            set_payload(1);
            m_cyc = m_cyc | NM'($urandom_range(1, (1 << NM) - 1));
            m_stb = m_cyc;
            tenure($urandom_range(1, 3), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), w);
        end
        m_cyc = '0;
        m_stb = '0;
        @(posedge clk) #1;

        // Reset mid-transfer clears outputs without a clock edge
        set_payload(1);
        m_cyc = 2'b10;
        m_stb = 2'b10;
        @(posedge clk) #1;
        @(negedge clk);
        chk("t5_gnt", gnt, 2'b10);
        #2 s_ack = 1'b1;
        #1;
        chk("t5_pre_ack", m_ack, 2'b10);
        rst = 1'b1;
        #1;
        chk("t5_rst_scyc", s_cyc, 1'b0);
        chk("t5_rst_gnt", gnt, 2'b00);
        chk("t5_rst_ack", m_ack, 2'b00);
        chk("t5_rst_busy", busy, 1'b0);
        @(posedge clk) #1;
        chk("t5_rst_held", gnt, 2'b00);
        rst   = 1'b0;
        s_ack = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        mdl_ptr = 0;
        @(posedge clk) #1;
        set_payload(0);
        set_payload(1);
        m_cyc = 2'b11;
        m_stb = 2'b11;
        tenure(1, 1'b0, 1'b0, 1'b0, w);
        chk("t5_priority", 64'(w), 64'd0);
        m_cyc = '0;
        m_stb = '0;
        @(posedge clk) #1;

        // Stalled bridge
        set_payload(0);
        m_cyc = 2'b01;
        m_stb = 2'b01;
        w = pick_model(m_cyc);
        s_ack    = 1'b0;
        s_data_i = 32'hDEAD_BEEF;
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= int'(TO); c++) begin
            @(posedge clk) #1;
            @(negedge clk);
            if (c < int'(TO)) begin
                chk("to_wait_ack", m_ack, '0);
                chk("to_wait_pulse", timeout, 1'b0);
                chk("to_wait_scyc", s_cyc, 1'b1);
            end else begin
                chk("to_ack", m_ack, onehot(w));
                chk("to_rdata", m_data_o, '0);
                chk("to_pulse", timeout, 1'b1);
                chk("to_scyc", s_cyc, 1'b0);
                chk("to_sstb", s_stb, 1'b0);
            end
        end
        @(posedge clk) #1;
        m_cyc = '0;
        m_stb = '0;
        @(negedge clk);
        chk("to_after_busy", busy, 1'b0);
        chk("to_after_gnt", gnt, '0);
        chk("to_after_pulse", timeout, 1'b0);
`else
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk) #1;
            @(negedge clk);
            chk("stall_no_timeout", timeout, 1'b0);
        end
        chk("stall_gnt", gnt, onehot(w));
        chk("stall_scyc", s_cyc, 1'b1);
        chk("stall_busy", busy, 1'b1);
        chk("stall_no_ack", m_ack, '0);
        @(posedge clk) #1;
        m_cyc = '0;
        m_stb = '0;
`endif
        @(posedge clk) #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
